// File: rtl/sram_bist_pkg.sv
// March C- BIST shared definitions: FSM states, element table, data patterns.
package sram_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned NUM_ELEMENTS = 6;
  localparam int unsigned ELEM_W       = 3;
  localparam int unsigned TBL_W        = 1 << ELEM_W;

  // Data pattern bits, replicated across the word by the user.
  localparam logic PAT_ZERO = 1'b0;
  localparam logic PAT_ONE  = 1'b1;

  // Per-element table, bit i describes element i:
  // E0 up(w0) E1 up(r0,w1) E2 up(r1,w0) E3 down(r0,w1) E4 down(r1,w0) E5 down(r0)
  localparam logic [TBL_W-1:0] ELEM_DOWN    = 8'b0011_1000;
  localparam logic [TBL_W-1:0] ELEM_TWO_OPS = 8'b0001_1110;
  localparam logic [TBL_W-1:0] OP0_WRITE    = 8'b0000_0001;
  localparam logic [TBL_W-1:0] OP0_VAL      = 8'b0001_0100;
  localparam logic [TBL_W-1:0] OP1_VAL      = 8'b0000_1010;

  function automatic logic elem_is_down(input logic [ELEM_W-1:0] elem);
    return ELEM_DOWN[elem];
  endfunction

  function automatic logic elem_has_two_ops(input logic [ELEM_W-1:0] elem);
    return ELEM_TWO_OPS[elem];
  endfunction

  // The second op of a two-op element is always a write.
  function automatic logic op_is_write(input logic [ELEM_W-1:0] elem, input logic phase);
    return phase ? 1'b1 : OP0_WRITE[elem];
  endfunction

  function automatic logic op_value(input logic [ELEM_W-1:0] elem, input logic phase);
    return phase ? (OP1_VAL[elem] ? PAT_ONE : PAT_ZERO) : (OP0_VAL[elem] ? PAT_ONE : PAT_ZERO);
  endfunction

endpackage

// File: rtl/sram_march_bist_if.sv
// SRAM macro port bundle between the BIST engine (master) and the memory (slave).
interface sram_march_bist_if #(
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WMASK_WIDTH = 4
) ();

  logic                   sram_we;
  logic [WMASK_WIDTH-1:0] sram_wmask;
  logic [ADDR_WIDTH-1:0]  sram_addr;
  logic [DATA_WIDTH-1:0]  sram_din;
  logic [DATA_WIDTH-1:0]  sram_dout;

  modport master (
    output sram_we,
    output sram_wmask,
    output sram_addr,
    output sram_din,
    input  sram_dout
  );

  modport slave (
    input  sram_we,
    input  sram_wmask,
    input  sram_addr,
    input  sram_din,
    output sram_dout
  );

endinterface

// File: rtl/sram_bist_addr_gen.sv
// Up/down march address counter; loads the element start address and flags the last address.
module sram_bist_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  load_down_i,
  input  logic                  step_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  down_q, down_d;
  logic                  last_q, last_d;

  // Next address: load at element boundaries, otherwise step in the latched direction.
  always_comb begin
    addr_d = addr_q;
    down_d = down_q;
    if (load_i) begin
      down_d = load_down_i;
      addr_d = load_down_i ? ADDR_MAX : '0;
    end else if (step_i) begin
      addr_d = down_q ? (addr_q - ADDR_WIDTH'(1)) : (addr_q + ADDR_WIDTH'(1));
    end
    last_d = down_d ? (addr_d == '0) : (addr_d == ADDR_MAX);
  end

  // Address, direction and last-address flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      down_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      down_q <= down_d;
      last_q <= last_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = last_q;

endmodule

// File: rtl/sram_march_bist.sv
// March C- SRAM BIST engine: one op per cycle, read compare two edges after issue.
// Build option SRAM_BIST_STOP_ON_FAIL_EN: abort the run at the first mismatch.
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WMASK_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [ADDR_WIDTH-1:0]  fail_addr,
  output logic [2:0]             fail_element,
  output logic [DATA_WIDTH-1:0]  fail_data,
  sram_march_bist_if.master      sram
);

  state_e                 state_q, state_d;
  logic [ELEM_W-1:0]      elem_q, elem_d;
  logic                   phase_q, phase_d;
  logic                   we_q, we_d;
  logic [WMASK_WIDTH-1:0] wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0]  din_q, din_d;
  logic                   rd_q, rd_d;
  logic                   rd_val_q, rd_val_d;
  logic                   cmp_vld_q, cmp_vld_d;
  logic                   cmp_val_q, cmp_val_d;
  logic [ADDR_WIDTH-1:0]  cmp_addr_q, cmp_addr_d;
  logic [ELEM_W-1:0]      cmp_elem_q, cmp_elem_d;
  logic                   fail_q, fail_d;
  logic [ADDR_WIDTH-1:0]  fail_addr_q, fail_addr_d;
  logic [ELEM_W-1:0]      fail_elem_q, fail_elem_d;
  logic [DATA_WIDTH-1:0]  fail_data_q, fail_data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   issue;
  logic                   iss_wr;
  logic                   iss_val;
  logic                   mismatch;
  logic                   stop;
  logic                   ag_load;
  logic                   ag_load_down;
  logic                   ag_step;
  logic                   ag_last;
  logic [ADDR_WIDTH-1:0]  ag_addr;

  sram_bist_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .load_i      (ag_load),
    .load_down_i (ag_load_down),
    .step_i      (ag_step),
    .addr_o      (ag_addr),
    .last_o      (ag_last)
  );

  // Sequencing, op issue, compare pipeline and first-fail capture.
  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    phase_d      = phase_q;
    issue        = 1'b0;
    ag_load      = 1'b0;
    ag_load_down = 1'b0;
    ag_step      = 1'b0;
    fail_d       = fail_q;
    fail_addr_d  = fail_addr_q;
    fail_elem_d  = fail_elem_q;
    fail_data_d  = fail_data_q;

    mismatch = cmp_vld_q && (sram.sram_dout != {DATA_WIDTH{cmp_val_q}});
`ifdef SRAM_BIST_STOP_ON_FAIL_EN
    stop = mismatch && (state_q == ST_RUN);
`else
    stop = 1'b0;
`endif

    if (mismatch && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = cmp_addr_q;
      fail_elem_d = cmp_elem_q;
      fail_data_d = sram.sram_dout;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_RUN;
          elem_d       = '0;
          phase_d      = 1'b0;
          issue        = 1'b1;
          ag_load      = 1'b1;
          ag_load_down = elem_is_down('0);
          fail_d       = 1'b0;
          fail_addr_d  = '0;
          fail_elem_d  = '0;
          fail_data_d  = '0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_DONE;
        end else if (phase_q == elem_has_two_ops(elem_q)) begin
          if (ag_last) begin
            if (elem_q == ELEM_W'(NUM_ELEMENTS - 1)) begin
              state_d = ST_DRAIN;
            end else begin
              elem_d       = elem_q + ELEM_W'(1);
              phase_d      = 1'b0;
              issue        = 1'b1;
              ag_load      = 1'b1;
              ag_load_down = elem_is_down(elem_q + ELEM_W'(1));
            end
          end else begin
            phase_d = 1'b0;
            issue   = 1'b1;
            ag_step = 1'b1;
          end
        end else begin
          phase_d = 1'b1;
          issue   = 1'b1;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

    iss_wr   = op_is_write(elem_d, phase_d);
    iss_val  = op_value(elem_d, phase_d);
    we_d     = issue && iss_wr;
    wmask_d  = {WMASK_WIDTH{we_d}};
    din_d    = issue ? {DATA_WIDTH{iss_val}} : din_q;
    rd_d     = issue && !iss_wr;
    rd_val_d = iss_val;

    // The read on the bus now is sampled by the SRAM at this edge; compare its data next edge.
    cmp_vld_d  = rd_q && !stop;
    cmp_val_d  = rd_val_q;
    cmp_addr_d = ag_addr;
    cmp_elem_d = elem_q;

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      elem_q      <= '0;
      phase_q     <= 1'b0;
      we_q        <= 1'b0;
      wmask_q     <= '0;
      din_q       <= '0;
      rd_q        <= 1'b0;
      rd_val_q    <= 1'b0;
      cmp_vld_q   <= 1'b0;
      cmp_val_q   <= 1'b0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      phase_q     <= phase_d;
      we_q        <= we_d;
      wmask_q     <= wmask_d;
      din_q       <= din_d;
      rd_q        <= rd_d;
      rd_val_q    <= rd_val_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_val_q   <= cmp_val_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_data_q <= fail_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign fail            = fail_q;
  assign fail_addr       = fail_addr_q;
  assign fail_element    = fail_elem_q;
  assign fail_data       = fail_data_q;
  assign sram.sram_we    = we_q;
  assign sram.sram_wmask = wmask_q;
  assign sram.sram_addr  = ag_addr;
  assign sram.sram_din   = din_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Directed bench for sram_march_bist with a 64x32 SRAM model and an optional stuck-at-1 fault.
module tb_sram_march_bist;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;
  localparam int LOGN = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_element;
  logic [DW-1:0] fail_data;

  sram_march_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW)) sif ();

  sram_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .fail_addr    (fail_addr),
    .fail_element (fail_element),
    .fail_data    (fail_data),
    .sram         (sif)
  );

  always #5 clk = ~clk;

  // SRAM model: byte-masked write, registered read, optional bit 5 stuck-at-1 at address 10.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] dout_q = '0;
  logic          fault_en = 1'b0;

  always @(posedge clk) begin
    if (sif.sram_we) begin
      for (int b = 0; b < int'(MW); b++)
        if (sif.sram_wmask[b]) mem[sif.sram_addr][8*b +: 8] <= sif.sram_din[8*b +: 8];
    end else begin
      dout_q <= mem[sif.sram_addr] | ((fault_en && sif.sram_addr == AW'(10)) ? 32'h0000_0020 : 32'h0);
    end
  end
  assign sif.sram_dout = dout_q;

  // Per-edge log, indexed by edge number relative to the start edge.
  logic          log_we    [0:LOGN-1];
  logic [MW-1:0] log_wmask [0:LOGN-1];
  logic [AW-1:0] log_addr  [0:LOGN-1];
  logic [DW-1:0] log_din   [0:LOGN-1];
  logic          log_busy  [0:LOGN-1];
  logic          log_done  [0:LOGN-1];
  logic          log_fail  [0:LOGN-1];
  int            edge_idx;
  int            n_cmp = 0;
  int            n_mis = 0;

  task automatic log_edge();
    log_we[edge_idx]    = sif.sram_we;
    log_wmask[edge_idx] = sif.sram_wmask;
    log_addr[edge_idx]  = sif.sram_addr;
    log_din[edge_idx]   = sif.sram_din;
    log_busy[edge_idx]  = busy;
    log_done[edge_idx]  = done;
    log_fail[edge_idx]  = fail;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edge_idx = 0;
    log_edge();
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      edge_idx++;
      log_edge();
    end
  endtask

  function automatic int first_done();
    for (int k = 0; k <= edge_idx; k++)
      if (log_done[k] === 1'b1) return k;
    return -1;
  endfunction

  function automatic int count_writes(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++)
      if (log_we[k] === 1'b1) c++;
    return c;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_fail", 64'(fail), 64'd0);
    check("rst_we", 64'(sif.sram_we), 64'd0);
    check("rst_wmask", 64'(sif.sram_wmask), 64'd0);
    check("rst_addr", 64'(sif.sram_addr), 64'd0);
    check("rst_din", 64'(sif.sram_din), 64'd0);
    check("rst_fail_fields", {fail_addr, fail_element, fail_data}, 64'd0);

    // Run 1: fault-free, with an ignored start pulse at cycle 100
    step(2);
    start_pulse();
    step(99);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(545);
    check("r1_busy_e0", 64'(log_busy[0]), 64'd1);
    check("r1_e0_first_we", 64'(log_we[0]), 64'd1);
    check("r1_e0_first_addr", 64'(log_addr[0]), 64'd0);
    check("r1_e0_first_din", 64'(log_din[0]), 64'h0);
    check("r1_e0_first_wmask", 64'(log_wmask[0]), 64'hf);
    check("r1_e0_last_addr", 64'(log_addr[63]), 64'd63);
    check("r1_e1_first_addr", 64'(log_addr[64]), 64'd0);
    check("r1_e1_first_we", 64'(log_we[64]), 64'd0);
    check("r1_e1_first_wmask", 64'(log_wmask[64]), 64'd0);
    check("r1_e1_w1_din", 64'(log_din[65]), 64'hffff_ffff);
    check("r1_e3_first_addr", 64'(log_addr[320]), 64'd63);
    check("r1_e3_first_we", 64'(log_we[320]), 64'd0);
    check("r1_e3_last_addr", 64'(log_addr[447]), 64'd0);
    check("r1_e3_last_we", 64'(log_we[447]), 64'd1);
    check("r1_e5_last_addr", 64'(log_addr[639]), 64'd0);
    check("r1_e5_last_we", 64'(log_we[639]), 64'd0);
    check("r1_write_count", 64'(count_writes(0, 639)), 64'd320);
    check("r1_drain_we", 64'(log_we[640]), 64'd0);
    check("r1_drain_wmask", 64'(log_wmask[640]), 64'd0);
    check("r1_busy_640", 64'(log_busy[640]), 64'd1);
    check("r1_busy_641", 64'(log_busy[641]), 64'd0);
    check("r1_done_edge", 64'(first_done()), 64'd641);
    check("r1_fail", 64'(fail), 64'd0);
    check("r1_done_held", 64'(done), 64'd1);

    // Run 2: start from DONE with bit 5 of address 10 stuck at 1
    fault_en = 1'b1;
    start_pulse();
    step(645);
    check("r2_fail_85", 64'(log_fail[85]), 64'd0);
    check("r2_fail_86", 64'(log_fail[86]), 64'd1);
    check("r2_fail", 64'(fail), 64'd1);
    check("r2_fail_addr", 64'(fail_addr), 64'd10);
    check("r2_fail_element", 64'(fail_element), 64'd1);
    check("r2_fail_data", 64'(fail_data), 64'h0000_0020);
`ifdef SRAM_BIST_STOP_ON_FAIL_EN
    check("r2_done_edge", 64'(first_done()), 64'd86);
    check("r2_writes_after_stop", 64'(count_writes(86, 645)), 64'd0);
    check("r2_busy_86", 64'(log_busy[86]), 64'd0);
`else
    check("r2_done_edge", 64'(first_done()), 64'd641);
    check("r2_write_count", 64'(count_writes(0, 639)), 64'd320);
`endif

    // Run 3: start from DONE after a failed run clears the capture and reruns clean
    fault_en = 1'b0;
    start_pulse();
    check("r3_clr_fail", 64'(fail), 64'd0);
    check("r3_clr_fail_addr", 64'(fail_addr), 64'd0);
    check("r3_clr_fail_element", 64'(fail_element), 64'd0);
    check("r3_clr_fail_data", 64'(fail_data), 64'd0);
    check("r3_clr_done", 64'(done), 64'd0);
    step(645);
    check("r3_done_edge", 64'(first_done()), 64'd641);
    check("r3_fail", 64'(fail), 64'd0);

    // Run 4: faulty run interrupted by reset at cycle 300
    fault_en = 1'b1;
    start_pulse();
    step(299);
    check("r4_fail_299", 64'(log_fail[299]), 64'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("r4_rst_busy", 64'(log_busy[300]), 64'd0);
    check("r4_rst_we", 64'(log_we[300]), 64'd0);
    check("r4_rst_fail", 64'(log_fail[300]), 64'd0);
    check("r4_rst_done", 64'(log_done[300]), 64'd0);
    check("r4_rst_fail_fields", {fail_addr, fail_element, fail_data}, 64'd0);
    step(3);
    check("r4_idle_fail", 64'(fail), 64'd0);

    // Run 5: fault-free restart from IDLE
    fault_en = 1'b0;
    start_pulse();
    step(645);
    check("r5_done_edge", 64'(first_done()), 64'd641);
    check("r5_fail", 64'(fail), 64'd0);
    check("r5_write_count", 64'(count_writes(0, 639)), 64'd320);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
